// File: rtl/img_pkg.sv
// Shared image geometry, pixel type and ROI reader state encoding.
// Reused by the image ROM and the other image-path blocks.
package img_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int X_W    = $clog2(IMG_W + 1);
  localparam int Y_W    = $clog2(IMG_H + 1);

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } roi_state_t;

endpackage

// File: rtl/img_roi_reader_if.sv
// Pixel stream bundle: valid/ready handshake plus frame markers.
// Master drives the pixel, slave drives ready.
interface img_roi_reader_if;
  import img_pkg::*;

  logic   m_valid;
  logic   m_ready;
  pixel_t m_data;
  logic   m_sof;
  logic   m_eol;
  logic   m_eof;

  modport master (
    output m_valid,
    output m_data,
    output m_sof,
    output m_eol,
    output m_eof,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_sof,
    input  m_eol,
    input  m_eof,
    output m_ready
  );

endinterface

// File: rtl/img_roi_reader.sv
// Walks a rectangular ROI of the image ROM in row-major order and
// emits it as a registered pixel stream with sof/eol/eof markers.
module img_roi_reader
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [X_W-1:0]    roi_x,
  input  logic [Y_W-1:0]    roi_y,
  input  logic [X_W-1:0]    roi_w,
  input  logic [Y_W-1:0]    roi_h,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  pixel_t            rom_data,
  img_roi_reader_if.master  m
);

  localparam int XE_W = X_W + 1;
  localparam int YE_W = Y_W + 1;

  roi_state_t        state_q, state_d;
  logic [X_W-1:0]    w_q, w_d;
  logic [Y_W-1:0]    h_q, h_d;
  logic [X_W-1:0]    cx_q, cx_d;
  logic [Y_W-1:0]    cy_q, cy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  pixel_t            data_q, data_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [XE_W-1:0]   x_end;
  logic [YE_W-1:0]   y_end;
  logic              bad_roi;
  logic [ADDR_W-1:0] base_addr;
  logic              row_end;
  logic              last_row;

  // One extra bit so x+w and y+h cannot wrap before the bound test.
  assign x_end   = {1'b0, roi_x} + {1'b0, roi_w};
  assign y_end   = {1'b0, roi_y} + {1'b0, roi_h};
  assign bad_roi = (roi_w == '0) || (roi_h == '0) ||
                   (x_end > XE_W'(IMG_W)) ||
                   (y_end > YE_W'(IMG_H));

  // y*320 as y*256 + y*64
  assign base_addr = ADDR_W'({roi_y, 8'b0}) +
                     ADDR_W'({roi_y, 6'b0}) +
                     ADDR_W'(roi_x);

  assign row_end  = (cx_q == w_q - X_W'(1));
  assign last_row = (cy_q == h_q - Y_W'(1));

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_roi) begin
            err_d = 1'b1;
          end else begin
            w_d     = roi_w;
            h_d     = roi_h;
            cx_d    = '0;
            cy_d    = '0;
            addr_d  = base_addr;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!valid_q || m.m_ready) begin
          data_d  = rom_data;
          valid_d = 1'b1;
          sof_d   = (cx_q == '0) && (cy_q == '0);
          eol_d   = row_end;
          eof_d   = row_end && last_row;
          if (!row_end) begin
            cx_d   = cx_q + X_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else if (!last_row) begin
            cx_d   = '0;
            cy_d   = cy_q + Y_W'(1);
            addr_d = addr_q + ADDR_W'(IMG_W) -
                     ADDR_W'(w_q) + ADDR_W'(1);
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (m.m_ready) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eol_d   = 1'b0;
          eof_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rom_addr  = (state_q == RUN) ? addr_q : '0;
  assign m.m_valid = valid_q;
  assign m.m_data  = data_q;
  assign m.m_sof   = sof_q;
  assign m.m_eol   = eol_q;
  assign m.m_eof   = eof_q;

endmodule
